// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract unit: one CHUNK-bit slice per stage, with the carry
// registered between stages and a valid/ready handshake on both sides.
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int CHUNK = WIDTH / STAGES;

  // Stage k holds the operand pair, the sum with slices 0..k finished, and the carry out of slice k
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic             v_q [STAGES];
  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  logic             c_d [STAGES];
  logic             v_d [STAGES];
  logic             ovf_q, ovf_d;
  logic             adv;

  assign adv       = !v_q[STAGES-1] || out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign carry     = c_q[STAGES-1];
  assign overflow  = ovf_q;

  always_comb begin
    logic [WIDTH-1:0] a_s, b_s, s_s;
    logic             ci_s, v_s;
    logic [CHUNK:0]   slice;
    a_s   = '0;
    b_s   = '0;
    s_s   = '0;
    ci_s  = 1'b0;
    v_s   = 1'b0;
    slice = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        a_s  = a;
        b_s  = sub ? ~b : b;
        s_s  = '0;
        ci_s = sub ? 1'b1 : c;
        v_s  = in_valid;
      end else begin
        a_s  = a_q[k-1];
        b_s  = b_q[k-1];
        s_s  = s_q[k-1];
        ci_s = c_q[k-1];
        v_s  = v_q[k-1];
      end
      slice = {1'b0, a_s[k*CHUNK +: CHUNK]} + {1'b0, b_s[k*CHUNK +: CHUNK]}
            + {{CHUNK{1'b0}}, ci_s};
      s_d[k] = s_s;
      s_d[k][k*CHUNK +: CHUNK] = slice[CHUNK-1:0];
      a_d[k] = a_s;
      b_d[k] = b_s;
      c_d[k] = slice[CHUNK];
      v_d[k] = v_s;
    end
    // Carry into the MSB is recovered from the MSB sum bit and its two operand bits
    ovf_d = (s_d[STAGES-1][WIDTH-1] ^ a_d[STAGES-1][WIDTH-1] ^ b_d[STAGES-1][WIDTH-1])
          ^ c_d[STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
        v_q[k] <= v_d[k];
      end
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: directed corner cases, stall, mid-flight reset
// and a long randomised stream checked against an arithmetic reference model.
module tb_pipelined_adder;
  localparam int WIDTH  = 16;
  localparam int STAGES = 4;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             c = 1'b0;
  logic             sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry(carry), .overflow(overflow)
  );

  initial forever #5 clk = ~clk;

  // Reference: plain integer arithmetic on unsigned and signed interpretations
  function automatic exp_t model(logic [WIDTH-1:0] ua, logic [WIDTH-1:0] ub,
                                 logic ci, logic s);
    exp_t   e;
    longint u_a, u_b, s_a, s_b, r, sr;
    longint smax, smin;
    u_a  = longint'(ua);
    u_b  = longint'(ub);
    s_a  = longint'($signed(ua));
    s_b  = longint'($signed(ub));
    smax = (longint'(1) << (WIDTH - 1)) - 1;
    smin = -(longint'(1) << (WIDTH - 1));
    if (s) begin
      r       = u_a - u_b;
      e.carry = (u_a >= u_b);
      sr      = s_a - s_b;
    end else begin
      r       = u_a + u_b + longint'(ci);
      e.carry = (r >= (longint'(1) << WIDTH));
      sr      = s_a + s_b + longint'(ci);
    end
    e.sum = r[WIDTH-1:0];
    e.ovf = (sr > smax) || (sr < smin);
    return e;
  endfunction

  task automatic chk(string name, longint act, longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard, sampled on the falling edge
  logic             held = 1'b0;
  logic [WIDTH-1:0] p_sum;
  logic             p_carry, p_ovf, p_valid;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      chk("in_ready", longint'(in_ready), longint'(!out_valid || out_ready));
      if (held) begin
        chk("hold_valid", longint'(out_valid), longint'(p_valid));
        chk("hold_sum", longint'(sum), longint'(p_sum));
        chk("hold_carry", longint'(carry), longint'(p_carry));
        chk("hold_ovf", longint'(overflow), longint'(p_ovf));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("sum", longint'(sum), longint'(e.sum));
          chk("carry", longint'(carry), longint'(e.carry));
          chk("overflow", longint'(overflow), longint'(e.ovf));
        end
      end
      if (in_valid && in_ready) sb.push_back(model(a, b, c, sub));
      held    = out_valid && !out_ready;
      p_valid = out_valid;
      p_sum   = sum;
      p_carry = carry;
      p_ovf   = overflow;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operand set and return just after the edge that accepted it
  task automatic send(logic [WIDTH-1:0] ta, logic [WIDTH-1:0] tb, logic tc, logic ts);
    bit ok;
    in_valid = 1'b1;
    a = ta; b = tb; c = tc; sub = ts;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      ok = in_ready;
      step();
      if (ok) return;
    end
    chk("accept_timeout", 1, 0);
  endtask

  task automatic dir_op(logic [WIDTH-1:0] ta, logic [WIDTH-1:0] tb, logic tc, logic ts);
    int n;
    send(ta, tb, tc, ts);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < STAGES + 5) begin
      step();
      n++;
    end
    chk("latency", longint'(n), longint'(STAGES));
    step();
    chk("single_pulse", longint'(out_valid), 0);
  endtask

  bit rnd_done;

  initial begin
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_sum", longint'(sum), 0);
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_carry", longint'(carry), 0);
    chk("rst_overflow", longint'(overflow), 0);

    // Directed corners, with fixed expectations beside the model's
    chk("model_wrap", longint'(model(16'hFFFF, 16'h0001, 1'b0, 1'b0)), longint'({16'h0000, 1'b1, 1'b0}));
    chk("model_sub_ovf", longint'(model(16'h8000, 16'h0001, 1'b0, 1'b1)), longint'({16'h7FFF, 1'b1, 1'b1}));
    dir_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    dir_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    dir_op(16'h1234, 16'h0FFF, 1'b1, 1'b0);
    dir_op(16'h0005, 16'h0007, 1'b1, 1'b1);
    dir_op(16'h8000, 16'h0001, 1'b0, 1'b1);

    // Back-to-back stream with a 3-cycle downstream stall
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(16'(i * 16'h1111), 16'(16'hF00F - i), 1'(i), 1'b0);
        in_valid = 1'b0;
      end
      begin
        repeat (6) step();
        out_ready = 1'b0;
        repeat (3) step();
        out_ready = 1'b1;
      end
    join
    repeat (STAGES + 4) step();
    chk("stream_drained", longint'(sb.size()), 0);

    // Reset with three operations in flight
    for (int i = 0; i < 3; i++) send(16'(16'h0101 * (i + 1)), 16'h00FF, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", longint'(out_valid), 0);
    chk("midrst_sum", longint'(sum), 0);
    sb.delete();
    step();
    #2;
    rst_n = 1'b1;
    repeat (2 * STAGES + 2) step();
    dir_op(16'hABCD, 16'h1111, 1'b1, 1'b0);

    // Randomised stream with random gaps and back-pressure
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(3) == 0) begin
            in_valid = 1'b0;
            step();
          end
          send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end
        in_valid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          out_ready = ($urandom_range(3) != 0);
          step();
        end
        out_ready = 1'b1;
      end
    join
    for (int n = 0; n < 100 && sb.size() != 0; n++) step();
    chk("random_drained", longint'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
